// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side driver for custom_alu. Buffers tagged commands in a small FIFO, issues each
//   one to the combinational ALU for exactly one cycle, registers the result and returns it
//   with its tag over a valid/ready response channel. Supports result chaining through an
//   accumulator and flags opcodes the ALU does not implement.
// Ports:
//   CLK, RST_N                     clock, asynchronous active-low reset
//   CMD_VALID/READY, CMD_OP/A/B,   command channel; CHAIN selects accumulator as operand A
//   CMD_CHAIN, CMD_TAG
//   ALU_OP/A/B (out), ALU_Z (in)   registered operands to / combinational result from ALU
//   RSP_VALID/READY, RSP_Z/TAG/ERR response channel; ERR marks an illegal opcode
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_OP,
  input  logic [7:0] CMD_A,
  input  logic [7:0] CMD_B,
  input  logic       CMD_CHAIN,
  input  logic [3:0] CMD_TAG,
  output logic [3:0] ALU_OP,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  input  logic [7:0] ALU_Z,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_Z,
  output logic [3:0] RSP_TAG,
  output logic       RSP_ERR
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
  localparam logic [3:0] LastLegalOp = 4'd9;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
    logic [3:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            ready_en_q;  // keeps CMD_READY low until the first edge after reset

  state_e          state_q;
  logic [7:0]      acc_q;
  logic [3:0]      issue_tag_q;
  logic            issue_err_q;
  logic [3:0]      alu_op_q;
  logic [7:0]      alu_a_q, alu_b_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [7:0]      rsp_z_q;
  logic [3:0]      rsp_tag_q;

  cmd_t            head, push_cmd;
  logic            push, pop, fifo_empty;

  always_comb begin
    fifo_empty = (count_q == '0);
    CMD_READY  = ready_en_q && (count_q != FullCount);
    push       = CMD_VALID && CMD_READY;
    head       = mem_q[rd_ptr_q];
    push_cmd   = '{op: CMD_OP, a: CMD_A, b: CMD_B, chain: CMD_CHAIN, tag: CMD_TAG};
    // Pops only happen when the FSM is ready to start an ISSUE cycle.
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = !fifo_empty;
      StResp:  pop = RSP_READY && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_cmd;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      issue_tag_q <= '0;
      issue_err_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // Load the issue registers; ALU_* then hold until the next pop.
      if (pop) begin
        alu_op_q    <= head.op;
        alu_a_q     <= head.chain ? acc_q : head.a;
        alu_b_q     <= head.b;
        issue_tag_q <= head.tag;
        issue_err_q <= (head.op > LastLegalOp);
      end
      case (state_q)
        StIdle: begin
          if (pop) state_q <= StIssue;
        end
        StIssue: begin
          rsp_valid_q <= 1'b1;
          rsp_tag_q   <= issue_tag_q;
          rsp_err_q   <= issue_err_q;
          rsp_z_q     <= issue_err_q ? 8'h00 : ALU_Z;
          // Updated before any following ISSUE, so back-to-back chains see this result.
          if (!issue_err_q) acc_q <= ALU_Z;
          state_q <= StResp;
        end
        StResp: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= pop ? StIssue : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ALU_OP    = alu_op_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_Z     = rsp_z_q;
  assign RSP_TAG   = rsp_tag_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a behavioural stand-in for custom_alu.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CMD_VALID, CMD_READY, CMD_CHAIN;
  logic [3:0] CMD_OP, CMD_TAG;
  logic [7:0] CMD_A, CMD_B;
  logic [3:0] ALU_OP;
  logic [7:0] ALU_A, ALU_B, ALU_Z;
  logic       RSP_VALID, RSP_READY, RSP_ERR;
  logic [7:0] RSP_Z;
  logic [3:0] RSP_TAG;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stimulus and response logs.
  logic [3:0] c_op [16];
  logic [7:0] c_a  [16];
  logic [7:0] c_b  [16];
  logic       c_ch [16];
  logic [3:0] c_tag[16];
  logic [7:0] lz [16];
  logic [7:0] la [16];
  logic [3:0] lt [16];
  logic [3:0] lo [16];
  logic       le [16];
  int         lc [16];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in ALU: ops 0..9 defined, anything else returns a marker value.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << 1;
      4'd7: return a >> 1;
      4'd8: return a + 8'd1;
      4'd9: return ~(a & b);
      default: return 8'hEE;
    endcase
  endfunction

  assign ALU_Z = alu_model(ALU_OP, ALU_A, ALU_B);

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_A(CMD_A),
    .CMD_B(CMD_B), .CMD_CHAIN(CMD_CHAIN), .CMD_TAG(CMD_TAG),
    .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Z(ALU_Z),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_Z(RSP_Z), .RSP_TAG(RSP_TAG),
    .RSP_ERR(RSP_ERR)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one command and hold it until accepted (bounded).
  task automatic push_one(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic ch, input logic [3:0] tag, output bit ok);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_A = a; CMD_B = b; CMD_CHAIN = ch; CMD_TAG = tag;
    ok = 1'b0;
    for (int w = 0; w < 12; w++) begin
      if (CMD_READY) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    CMD_VALID = 1'b0;
  endtask

  // Log every cycle with RSP_VALID high; expects RSP_READY=1 so each such cycle is new.
  task automatic collect(input int n, input int limit, output int got);
    got = 0;
    for (int c = 0; c < limit && got < n; c++) begin
      if (RSP_VALID && got < 16) begin
        lz[got] = RSP_Z; lt[got] = RSP_TAG; le[got] = RSP_ERR;
        lo[got] = ALU_OP; la[got] = ALU_A; lc[got] = cyc;
        got++;
      end
      tick();
    end
  endtask

  task automatic run_cmds(input int n, output int got);
    int g;
    fork
      begin
        bit ok;
        for (int i = 0; i < n; i++) begin
          push_one(c_op[i], c_a[i], c_b[i], c_ch[i], c_tag[i], ok);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL push_timeout cmd %0d: CMD_READY never 1, required 1", i);
          end
        end
      end
      begin
        collect(n, 40 + 4 * n, g);
      end
    join
    got = g;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL rsp_count: got %0d responses, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_A = '0; CMD_B = '0;
    CMD_CHAIN = 1'b0; CMD_TAG = '0; RSP_READY = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({CMD_READY, RSP_VALID, RSP_Z, RSP_TAG, RSP_ERR, ALU_OP, ALU_A, ALU_B} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b z=%h tag=%h err=%b op=%h a=%h b=%h, required 0",
               CMD_READY, RSP_VALID, RSP_Z, RSP_TAG, RSP_ERR, ALU_OP, ALU_A, ALU_B);
    end
    tick(); tick();
    RST_N = 1'b1;
    tick();
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: CMD_READY=%b required 1", CMD_READY);
    end
  endtask

  task automatic test_single();
    bit ok;
    RSP_READY = 1'b1;
    push_one(4'd0, 8'h00, 8'h00, 1'b0, 4'd3, ok);  // edge N
    checks++;
    if (!ok || RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_n: ok=%b RSP_VALID=%b required ok=1 vld=0", ok, RSP_VALID);
    end
    tick();  // edge N+1: ISSUE
    checks++;
    if (ALU_OP !== 4'd0 || RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: ALU_OP=%h vld=%b required 0/0", ALU_OP, RSP_VALID);
    end
    tick();  // edge N+2: RESP
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_TAG !== 4'd3 || RSP_Z !== 8'h00 || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: vld=%b tag=%h z=%h err=%b required 1/3/00/0",
               RSP_VALID, RSP_TAG, RSP_Z, RSP_ERR);
    end
    tick();
    checks++;
    if (RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_done: RSP_VALID=%b required 0", RSP_VALID);
    end
  endtask

  task automatic test_sweep();
    int got;
    logic [7:0] exp_z [10];
    exp_z = '{8'h96, 8'h1E, 8'h18, 8'h7E, 8'h66, 8'hA5, 8'hB4, 8'h2D, 8'h5B, 8'hE7};
    for (int i = 0; i < 10; i++) begin
      c_op[i] = 4'(i); c_a[i] = 8'h5A; c_b[i] = 8'h3C; c_ch[i] = 1'b0; c_tag[i] = 4'(i);
    end
    run_cmds(10, got);
    for (int i = 0; i < got && i < 10; i++) begin
      checks++;
      if (lt[i] !== 4'(i) || lz[i] !== exp_z[i] || le[i] !== 1'b0) begin
        errors++;
        $display("FAIL sweep_rsp %0d: tag=%h z=%h err=%b required tag=%h z=%h err=0",
                 i, lt[i], lz[i], le[i], 4'(i), exp_z[i]);
      end
      if (i > 0) begin
        checks++;
        if (lc[i] - lc[i-1] != 2) begin
          errors++;
          $display("FAIL sweep_spacing %0d: %0d cycles required 2", i, lc[i] - lc[i-1]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int got;
    c_op[0] = 4'd0;  c_a[0] = 8'h10; c_b[0] = 8'h05; c_ch[0] = 1'b0; c_tag[0] = 4'd1;
    c_op[1] = 4'hC;  c_a[1] = 8'h11; c_b[1] = 8'h22; c_ch[1] = 1'b0; c_tag[1] = 4'd7;
    c_op[2] = 4'd0;  c_a[2] = 8'hFF; c_b[2] = 8'h01; c_ch[2] = 1'b1; c_tag[2] = 4'd8;
    run_cmds(3, got);
    if (got == 3) begin
      checks++;
      if (le[0] !== 1'b0 || lz[0] !== 8'h15) begin
        errors++;
        $display("FAIL illegal_pre: err=%b z=%h required 0/15", le[0], lz[0]);
      end
      checks++;
      if (le[1] !== 1'b1 || lz[1] !== 8'h00 || lt[1] !== 4'd7 || lo[1] !== 4'hC) begin
        errors++;
        $display("FAIL illegal_rsp: err=%b z=%h tag=%h op=%h required 1/00/7/C",
                 le[1], lz[1], lt[1], lo[1]);
      end
      checks++;
      if (la[2] !== 8'h15 || lz[2] !== 8'h16 || le[2] !== 1'b0) begin
        errors++;
        $display("FAIL illegal_chain: alu_a=%h z=%h err=%b required 15/16/0",
                 la[2], lz[2], le[2]);
      end
    end
  endtask

  task automatic test_chain();
    int got;
    c_op[0] = 4'd0; c_a[0] = 8'h01; c_b[0] = 8'h02; c_ch[0] = 1'b0; c_tag[0] = 4'd2;
    c_op[1] = 4'd0; c_a[1] = 8'hFF; c_b[1] = 8'h02; c_ch[1] = 1'b1; c_tag[1] = 4'd4;
    run_cmds(2, got);
    if (got == 2) begin
      checks++;
      if (lz[0] !== 8'h03 || la[1] !== 8'h03 || lz[1] !== 8'h05 || lt[1] !== 4'd4) begin
        errors++;
        $display("FAIL chain: z0=%h alu_a1=%h z1=%h tag1=%h required 03/03/05/4",
                 lz[0], la[1], lz[1], lt[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int accepted = 0;
    int got;
    logic [3:0] op [6];
    logic [7:0] a  [6];
    logic [7:0] b  [6];
    logic [7:0] ez [5];
    op = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd0};
    a  = '{8'h20, 8'hF0, 8'h0F, 8'hFF, 8'h81, 8'h01};
    b  = '{8'h05, 8'h3C, 8'h30, 8'h0F, 8'h00, 8'h01};
    ez = '{8'h1B, 8'h30, 8'h3F, 8'hF0, 8'h02};
    RSP_READY = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_one(op[i], a[i], b[i], 1'b0, 4'(10 + i), ok);
      if (!ok) break;
      accepted++;
    end
    checks++;
    if (accepted != DEPTH + 1 || CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: accepted=%0d ready=%b required %0d/0",
               accepted, CMD_READY, DEPTH + 1);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (RSP_VALID !== 1'b1 || RSP_TAG !== 4'd10 || RSP_Z !== 8'h1B || RSP_ERR !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d: vld=%b tag=%h z=%h err=%b required 1/A/1B/0",
                 k, RSP_VALID, RSP_TAG, RSP_Z, RSP_ERR);
      end
      tick();
    end
    RSP_READY = 1'b1;
    collect(DEPTH + 2, 30, got);
    checks++;
    if (got != DEPTH + 1) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d required %0d", got, DEPTH + 1);
    end
    for (int i = 0; i < got && i < DEPTH + 1; i++) begin
      checks++;
      if (lt[i] !== 4'(10 + i) || lz[i] !== ez[i]) begin
        errors++;
        $display("FAIL bp_drain %0d: tag=%h z=%h required %h/%h",
                 i, lt[i], lz[i], 4'(10 + i), ez[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int got;
    RSP_READY = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_one(4'd0, 8'(i), 8'h01, 1'b0, 4'(i + 1), ok);
    checks++;
    if (CMD_READY !== 1'b0 || RSP_VALID !== 1'b1) begin
      errors++;
      $display("FAIL rm_full: ready=%b vld=%b required 0/1", CMD_READY, RSP_VALID);
    end
    RSP_READY = 1'b1;
    tick();  // now in ISSUE with DEPTH-1 entries queued
    checks++;
    if (RSP_VALID !== 1'b0 || ALU_A !== 8'h01) begin
      errors++;
      $display("FAIL rm_issue: vld=%b alu_a=%h required 0/01", RSP_VALID, ALU_A);
    end
    #3 RST_N = 1'b0;
    #1;
    checks++;
    if ({CMD_READY, RSP_VALID, RSP_Z, RSP_TAG, RSP_ERR, ALU_OP, ALU_A, ALU_B} !== '0) begin
      errors++;
      $display("FAIL rm_async: rdy=%b vld=%b z=%h tag=%h err=%b op=%h a=%h b=%h, required 0",
               CMD_READY, RSP_VALID, RSP_Z, RSP_TAG, RSP_ERR, ALU_OP, ALU_A, ALU_B);
    end
    #2 RST_N = 1'b1;
    tick();
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL rm_ready: CMD_READY=%b required 1", CMD_READY);
    end
    collect(1, 15, got);
    checks++;
    if (got != 0) begin
      errors++;
      $display("FAIL rm_stale: %0d responses after reset, required 0", got);
    end
    // Accumulator is back to 0, so a chained add returns B.
    c_op[0] = 4'd0; c_a[0] = 8'hAA; c_b[0] = 8'h07; c_ch[0] = 1'b1; c_tag[0] = 4'd5;
    run_cmds(1, got);
    if (got == 1) begin
      checks++;
      if (la[0] !== 8'h00 || lz[0] !== 8'h07 || lt[0] !== 4'd5) begin
        errors++;
        $display("FAIL rm_after: alu_a=%h z=%h tag=%h required 00/07/5", la[0], lz[0], lt[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_illegal();
    test_chain();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
